// File: rtl/pdm_cic_decimator_if.sv
// PCM output bus of pdm_cic_decimator: sample, one-clk strobe, sticky clip flag and its clear.
interface pdm_cic_decimator_if;
  logic signed [15:0] pcm_data;
  logic               pcm_valid;
  logic               clip;
  logic               clip_clr;

  modport master (output pcm_data, output pcm_valid, output clip, input clip_clr);
  modport slave  (input pcm_data, input pcm_valid, input clip, output clip_clr);
endinterface

// File: rtl/pdm_cic_decimator.sv
// 4th-order CIC decimator (R = 2^DECIM_LOG2, M = 1) turning a 1-bit PDM stream into 16-bit PCM.
// Optional DC-blocking high-pass after saturation when PDM_DCBLOCK_EN is defined.
module pdm_cic_decimator #(
  parameter  int DECIM_LOG2 = 6,
  localparam int ACC_W      = 4*DECIM_LOG2 + 2
) (
  input  logic                clk,
  input  logic                sysreset_n,
  input  logic                enable,
  input  logic                pdm_in,
  pdm_cic_decimator_if.master pcm
);

  localparam int SHIFT = 4*DECIM_LOG2 - 15;
  localparam logic [DECIM_LOG2-1:0] CNT_MAX = '1;

  logic [DECIM_LOG2-1:0] cnt;
  logic                  tick;
  logic signed [ACC_W-1:0] x_in;
  logic signed [ACC_W-1:0] i1, i2, i3, i4, i4_next;
  logic signed [ACC_W-1:0] comb_in;
  logic signed [ACC_W-1:0] c1, c2, c3, c4;
  logic signed [ACC_W-1:0] d1, d2, d3, d4;
  logic [4:0]            step;
  logic signed [16:0]    s;
  logic signed [15:0]    s_sat;
  logic                  s_clip;
  logic                  out_fire;
  logic signed [15:0]    out_val;
  logic                  clip_set;
  logic                  unused_bits;

  assign x_in    = pdm_in ? {{(ACC_W-1){1'b0}}, 1'b1} : {ACC_W{1'b1}};
  assign i4_next = i4 + i3;
  assign tick    = enable && (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!sysreset_n) begin
      cnt <= '0;
      i1  <= '0;
      i2  <= '0;
      i3  <= '0;
      i4  <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
      i1  <= i1 + x_in;
      i2  <= i2 + i1;
      i3  <= i3 + i2;
      i4  <= i4_next;
    end
  end

  // Comb stages run off a one-hot step chain so they finish even if enable drops after the tick.
  always_ff @(posedge clk) begin
    if (!sysreset_n) begin
      step    <= '0;
      comb_in <= '0;
      c1 <= '0; c2 <= '0; c3 <= '0; c4 <= '0;
      d1 <= '0; d2 <= '0; d3 <= '0; d4 <= '0;
    end else begin
      step <= {step[3:0], tick};
      if (tick) comb_in <= i4_next;
      if (step[0]) begin
        c1 <= comb_in - d1;
        d1 <= comb_in;
      end
      if (step[1]) begin
        c2 <= c1 - d2;
        d2 <= c1;
      end
      if (step[2]) begin
        c3 <= c2 - d3;
        d3 <= c2;
      end
      if (step[3]) begin
        c4 <= c3 - d4;
        d4 <= c3;
      end
    end
  end

  assign s           = c4[ACC_W-1:SHIFT];
  assign unused_bits = ^c4[SHIFT-1:0];

  always_comb begin
    s_sat  = s[15:0];
    s_clip = 1'b0;
    if (s[16] != s[15]) begin
      s_clip = 1'b1;
      s_sat  = s[16] ? 16'sh8000 : 16'sh7fff;
    end
  end

`ifdef PDM_DCBLOCK_EN
  logic signed [15:0] dc_x, dc_x1, dc_y1;
  logic               dc_step;
  logic signed [17:0] dc_y;
  logic signed [15:0] dc_sat;
  logic               dc_clip;
  logic signed [15:0] dc_leak;

  // Feedback uses the saturated output so the state stays bounded inside 18 bits.
  assign dc_leak = dc_y1 >>> 8;
  assign dc_y    = {{2{dc_x[15]}}, dc_x} - {{2{dc_x1[15]}}, dc_x1}
                 + {{2{dc_y1[15]}}, dc_y1} - {{2{dc_leak[15]}}, dc_leak};

  always_comb begin
    dc_sat  = dc_y[15:0];
    dc_clip = 1'b0;
    if (!((dc_y[17:15] == 3'b000) || (dc_y[17:15] == 3'b111))) begin
      dc_clip = 1'b1;
      dc_sat  = dc_y[17] ? 16'sh8000 : 16'sh7fff;
    end
  end

  always_ff @(posedge clk) begin
    if (!sysreset_n) begin
      dc_x    <= '0;
      dc_x1   <= '0;
      dc_y1   <= '0;
      dc_step <= 1'b0;
    end else begin
      dc_step <= step[4];
      if (step[4]) dc_x <= s_sat;
      if (dc_step) begin
        dc_x1 <= dc_x;
        dc_y1 <= dc_sat;
      end
    end
  end

  assign out_fire = dc_step;
  assign out_val  = dc_sat;
  assign clip_set = (step[4] && s_clip) || (dc_step && dc_clip);
`else
  assign out_fire = step[4];
  assign out_val  = s_sat;
  assign clip_set = step[4] && s_clip;
`endif

  // A saturating sample beats a simultaneous clip_clr.
  always_ff @(posedge clk) begin
    if (!sysreset_n) begin
      pcm.pcm_data  <= '0;
      pcm.pcm_valid <= 1'b0;
      pcm.clip      <= 1'b0;
    end else begin
      pcm.pcm_valid <= out_fire;
      if (out_fire) pcm.pcm_data <= out_val;
      if (clip_set)
        pcm.clip <= 1'b1;
      else if (pcm.clip_clr)
        pcm.clip <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Scoreboard bench for pdm_cic_decimator (default build, DECIM_LOG2 = 6).
module tb_pdm_cic_decimator;

  localparam int R   = 64;
  localparam int LAT = 5;

  typedef struct {
    int                 due;
    bit                 chk;
    logic signed [15:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic sysreset_n;
  logic enable;
  logic pdm_in;

  pdm_cic_decimator_if pcm_bus();

  pdm_cic_decimator #(.DECIM_LOG2(6)) dut (
    .clk        (clk),
    .sysreset_n (sysreset_n),
    .enable     (enable),
    .pdm_in     (pdm_in),
    .pcm        (pcm_bus)
  );

  always #5 clk = ~clk;

  exp_t               exp_q[$];
  exp_t               new_e;
  exp_t               got_e;
  int                 edge_no      = 0;
  int                 m_cnt        = 0;
  int                 m_ticks      = 0;
  int                 pat_idx      = 0;
  int                 settle_until = 0;
  int                 mode         = 0;
  logic signed [15:0] cur_exp      = 16'sd0;
  int                 n_compared   = 0;
  int                 n_mismatch   = 0;

  task automatic checkOutput(input string name, input int actual, input int required);
    n_compared++;
    if (actual !== required) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %0d, required %0d (edge %0d)", name, actual, required, edge_no);
    end
  endtask

  // Modes: 0 all-ones, 1 all-zeros, 2 alternating, 3 periodic 40-of-64 ones.
  function automatic logic pattern_bit();
    case (mode)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (pat_idx % 2) == 0;
      default: return (pat_idx % R) < 40;
    endcase
  endfunction

  task automatic applyStimulus(input int n);
    repeat (n) begin
      pdm_in = pattern_bit();
      @(negedge clk);
    end
  endtask

  task automatic setMode(input int m, input int val, input int settle);
    mode         = m;
    cur_exp      = 16'(val);
    settle_until = m_ticks + settle;
  endtask

  task automatic waitValid(input string name);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      applyStimulus(1);
      if (pcm_bus.pcm_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_compared++;
      n_mismatch++;
      $display("[TB] FAIL %s: no pcm_valid within 200 clks, required one", name);
    end
  endtask

  // Reference timing model: pushes the expected sample when a tick happens.
  always @(posedge clk) begin
    edge_no++;
    if (enable) pat_idx++;
    if (!sysreset_n) begin
      m_cnt   = 0;
      m_ticks = 0;
      exp_q.delete();
    end else if (enable) begin
      if (m_cnt == R-1) begin
        new_e.due = edge_no + LAT;
        new_e.chk = (m_ticks >= settle_until);
        new_e.val = cur_exp;
        exp_q.push_back(new_e);
        m_ticks++;
      end
      m_cnt = (m_cnt + 1) % R;
    end
  end

  // Monitor: pops and compares whenever the DUT presents a sample.
  always @(posedge clk) begin
    #1;
    while (exp_q.size() > 0 && exp_q[0].due < edge_no) begin
      n_compared++;
      n_mismatch++;
      $display("[TB] FAIL pcm_valid_missing: got no pulse, required at edge %0d (now %0d)",
               exp_q[0].due, edge_no);
      void'(exp_q.pop_front());
    end
    if (pcm_bus.pcm_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_compared++;
        n_mismatch++;
        $display("[TB] FAIL pcm_valid_unexpected: got pulse at edge %0d, required none", edge_no);
      end else begin
        got_e = exp_q.pop_front();
        checkOutput("pcm_valid_edge", edge_no, got_e.due);
        if (got_e.chk) checkOutput("pcm_data_sample", int'(pcm_bus.pcm_data), int'(got_e.val));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sysreset_n       = 1'b0;
    enable           = 1'b0;
    pdm_in           = 1'b1;
    pcm_bus.clip_clr = 1'b0;
    setMode(0, 32767, 0);
    applyStimulus(3);
    checkOutput("reset_pcm_data", int'(pcm_bus.pcm_data), 0);
    checkOutput("reset_pcm_valid", int'(pcm_bus.pcm_valid), 0);
    checkOutput("reset_clip", int'(pcm_bus.clip), 0);

    $display("[TB] all-ones from reset");
    sysreset_n   = 1'b1;
    enable       = 1'b1;
    settle_until = 4;
    applyStimulus(64*7);
    checkOutput("clip_after_ones", int'(pcm_bus.clip), 1);

    $display("[TB] clip_clr alone, then together with a saturating sample");
    waitValid("wait_clip_align");
    applyStimulus(20);
    pcm_bus.clip_clr = 1'b1;
    applyStimulus(1);
    pcm_bus.clip_clr = 1'b0;
    checkOutput("clip_cleared", int'(pcm_bus.clip), 0);
    applyStimulus(42);
    pcm_bus.clip_clr = 1'b1;
    applyStimulus(1);
    pcm_bus.clip_clr = 1'b0;
    checkOutput("valid_on_clr_edge", int'(pcm_bus.pcm_valid), 1);
    checkOutput("clip_set_wins", int'(pcm_bus.clip), 1);

    $display("[TB] alternating input");
    setMode(2, 0, 5);
    applyStimulus(64*3);
    pcm_bus.clip_clr = 1'b1;
    applyStimulus(1);
    pcm_bus.clip_clr = 1'b0;
    checkOutput("clip_clr_alt", int'(pcm_bus.clip), 0);
    applyStimulus(64*5);

    $display("[TB] all-zeros input");
    setMode(1, -32768, 5);
    applyStimulus(64*7);
    checkOutput("clip_zeros", int'(pcm_bus.clip), 0);

    $display("[TB] all-ones again");
    setMode(0, 32767, 5);
    applyStimulus(64*7);
    checkOutput("clip_resets", int'(pcm_bus.clip), 1);

    $display("[TB] periodic pattern with enable gap");
    setMode(3, 8192, 5);
    applyStimulus(64*7);
    waitValid("wait_gate_align");
    applyStimulus(30);
    enable = 1'b0;
    applyStimulus(100);
    checkOutput("hold_pcm_data", int'(pcm_bus.pcm_data), 8192);
    checkOutput("gap_pcm_valid", int'(pcm_bus.pcm_valid), 0);
    enable = 1'b1;
    applyStimulus(64*4);

    $display("[TB] reset two clks after a tick");
    waitValid("wait_reset_align");
    applyStimulus(60);
    sysreset_n = 1'b0;
    applyStimulus(1);
    checkOutput("midreset_pcm_data", int'(pcm_bus.pcm_data), 0);
    checkOutput("midreset_pcm_valid", int'(pcm_bus.pcm_valid), 0);
    checkOutput("midreset_clip", int'(pcm_bus.clip), 0);
    sysreset_n   = 1'b1;
    settle_until = 5;
    applyStimulus(64*8);
    applyStimulus(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
